// File: rtl/chunked_adder_accum.sv
// Multi-cycle adder/subtractor/accumulator that adds CHUNK bits per clock,
// LSB chunk first, with optional unsigned saturation of the final result.
module chunked_adder_accum #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    parameter int SAT   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [WIDTH-1:0] acc
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic IDLE = 1'b0;
    localparam logic RUN  = 1'b1;

    localparam logic [1:0] M_ADD = 2'b00;
    localparam logic [1:0] M_SUB = 2'b01;
    localparam logic [1:0] M_ACC = 2'b10;
    localparam logic [1:0] M_CLR = 2'b11;

    logic             state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cy_q, cy_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             amsb_q, amsb_d;
    logic             bmsb_q, bmsb_d;
    logic             sub_q, sub_d;
    logic             accm_q, accm_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             done_q, done_d;

    logic [CHUNK:0]   csum;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] fin_sum;
    logic             fin_ovf;
    logic             last;
    logic             load;

    // Operands shift right one chunk per cycle; partial result fills from the top.
    always_comb begin
        csum = {1'b0, opa_q[CHUNK-1:0]}
             + {1'b0, opb_q[CHUNK-1:0]}
             + {{CHUNK{1'b0}}, cy_q};
        raw = WIDTH'({csum[CHUNK-1:0], res_q} >> CHUNK);
        fin_ovf = (amsb_q == bmsb_q) && (raw[WIDTH-1] != amsb_q);
        fin_sum = raw;
        if (SAT != 0) begin
            if (!sub_q && csum[CHUNK]) begin
                fin_sum = '1;
            end else if (sub_q && !csum[CHUNK]) begin
                fin_sum = '0;
            end
        end
        last = (cnt_q == CW'(NCH - 1));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cy_d    = cy_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;
        sub_d   = sub_q;
        accm_d  = accm_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        acc_d   = acc_q;
        done_d  = 1'b0;
        load    = 1'b0;

        unique case (1'b1)
            (state_q == IDLE): begin
                if (start) begin
                    if (mode == M_CLR) begin
                        acc_d  = '0;
                        sum_d  = '0;
                        cout_d = 1'b0;
                        ovf_d  = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            (state_q == RUN): begin
                cy_d  = csum[CHUNK];
                res_d = raw;
                opa_d = opa_q >> CHUNK;
                opb_d = opb_q >> CHUNK;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    sum_d   = fin_sum;
                    cout_d  = csum[CHUNK];
                    ovf_d   = fin_ovf;
                    done_d  = 1'b1;
                    state_d = IDLE;
                    if (accm_q) begin
                        acc_d = fin_sum;
                    end
                    // Accepting here keeps back-to-back ops NCH cycles apart.
                    load = start && (mode != M_CLR);
                end
            end
            default: begin
            end
        endcase

        if (load) begin
            state_d = RUN;
            cnt_d   = '0;
            res_d   = '0;
            sub_d   = (mode == M_SUB);
            accm_d  = (mode == M_ACC);
            opa_d   = (mode == M_ACC) ? acc_d : a;
            opb_d   = (mode == M_ADD) ? b
                    : (mode == M_SUB) ? ~b
                    : a;
            cy_d    = (mode == M_SUB) ? 1'b1 : cin;
            amsb_d  = opa_d[WIDTH-1];
            bmsb_d  = opb_d[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cy_q    <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
            sub_q   <= 1'b0;
            accm_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            acc_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cy_q    <= cy_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            amsb_q  <= amsb_d;
            bmsb_q  <= bmsb_d;
            sub_q   <= sub_d;
            accm_q  <= accm_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign acc  = acc_q;

endmodule

// File: tb/tb_chunked_adder_accum.sv
// Bench for chunked_adder_accum: wrapping and saturating instances side by
// side, results checked against a whole-word reference through a queue.
module tb_chunked_adder_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;

    logic        busy0, done0, cout0, ovf0;
    logic [15:0] sum0, acc0;
    logic        busy1, done1, cout1, ovf1;
    logic [15:0] sum1, acc1;

    always #5 clk = ~clk;

    chunked_adder_accum #(.WIDTH(16), .CHUNK(4), .SAT(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .a(a), .b(b), .cin(cin),
        .busy(busy0), .done(done0), .sum(sum0),
        .cout(cout0), .ovf(ovf0), .acc(acc0)
    );

    chunked_adder_accum #(.WIDTH(16), .CHUNK(4), .SAT(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .a(a), .b(b), .cin(cin),
        .busy(busy1), .done(done1), .sum(sum1),
        .cout(cout1), .ovf(ovf1), .acc(acc1)
    );

    typedef struct packed {
        logic [15:0] s0;
        logic [15:0] s1;
        logic [15:0] a0;
        logic [15:0] a1;
        logic        c0;
        logic        o0;
        logic        c1;
        logic        o1;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] accm0 = 16'h0;
    logic [15:0] accm1 = 16'h0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void calc(input logic [1:0] m, input logic [15:0] av,
                                 input logic [15:0] bv, input logic ci,
                                 input logic sat, inout logic [15:0] accv,
                                 output logic [15:0] s, output logic co,
                                 output logic ov);
        logic [15:0] x;
        logic [15:0] y;
        logic        c;
        logic [16:0] r;
        x  = (m == 2'b10) ? accv : av;
        y  = (m == 2'b00) ? bv : (m == 2'b01) ? ~bv : av;
        c  = (m == 2'b01) ? 1'b1 : ci;
        r  = {1'b0, x} + {1'b0, y} + {16'd0, c};
        s  = r[15:0];
        co = r[16];
        ov = (x[15] == y[15]) && (s[15] != x[15]);
        if (sat) begin
            if (m != 2'b01 && co) s = 16'hFFFF;
            else if (m == 2'b01 && !co) s = 16'h0000;
        end
        if (m == 2'b10) accv = s;
    endfunction

    task automatic push(input logic [1:0] m, input logic [15:0] av,
                        input logic [15:0] bv, input logic ci);
        exp_t        e;
        logic [15:0] s;
        logic        co, ov;
        e = '0;
        if (m == 2'b11) begin
            accm0 = 16'h0;
            accm1 = 16'h0;
        end else begin
            calc(m, av, bv, ci, 1'b0, accm0, s, co, ov);
            e.s0 = s; e.c0 = co; e.o0 = ov;
            calc(m, av, bv, ci, 1'b1, accm1, s, co, ov);
            e.s1 = s; e.c1 = co; e.o1 = ov;
            e.a0 = accm0;
            e.a1 = accm1;
        end
        sbq.push_back(e);
    endtask

    // Scoreboard: every done pulse consumes one expected result.
    always @(negedge clk) begin
        exp_t e;
        if (done0 || done1) begin
            chk("done_pair", done1, done0);
            checks++;
            assert (sbq.size() > 0) else begin
                errors++;
                $error("FAIL spurious_done got=%0d exp=>0", sbq.size());
            end
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("sum_wrap", sum0, e.s0);
                chk("cout_wrap", cout0, e.c0);
                chk("ovf_wrap", ovf0, e.o0);
                chk("acc_wrap", acc0, e.a0);
                chk("sum_sat", sum1, e.s1);
                chk("cout_sat", cout1, e.c1);
                chk("ovf_sat", ovf1, e.o1);
                chk("acc_sat", acc1, e.a1);
            end
        end
    end

    task automatic run_op(input logic [1:0] m, input logic [15:0] av,
                          input logic [15:0] bv, input logic ci,
                          input string tag);
        mode = m; a = av; b = bv; cin = ci; start = 1'b1;
        push(m, av, bv, ci);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk({tag, "_busy"}, {busy1, busy0}, 2'b11);
            chk({tag, "_early_done"}, {done1, done0}, 2'b00);
            mode = 2'($urandom);
            a    = 16'($urandom);
            b    = 16'($urandom);
            cin  = 1'($urandom);
        end
        @(negedge clk);
        chk({tag, "_done"}, {done1, done0}, 2'b11);
        chk({tag, "_idle"}, {busy1, busy0}, 2'b00);
    endtask

    task automatic clr(input string tag);
        mode = 2'b11; a = 16'($urandom); start = 1'b1;
        push(2'b11, a, b, cin);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk({tag, "_done"}, {done1, done0}, 2'b11);
        chk({tag, "_busy"}, {busy1, busy0}, 2'b00);
        @(negedge clk);
        chk({tag, "_pulse"}, {done1, done0}, 2'b00);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        rst_n = 1'b0; start = 1'b0; mode = 2'b00;
        a = 16'h0; b = 16'h0; cin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {busy1, busy0}, 2'b00);
        chk("rst_done", {done1, done0}, 2'b00);
        chk("rst_sum", {sum1, sum0}, 32'h0);
        chk("rst_flags", {cout1, ovf1, cout0, ovf0}, 4'h0);
        chk("rst_acc", {acc1, acc0}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(2'b00, 16'h00FF, 16'h0001, 1'b0, "add_basic");
        run_op(2'b00, 16'hFFFF, 16'h0001, 1'b1, "add_carry");
        run_op(2'b00, 16'h7FFF, 16'h0001, 1'b0, "add_ovf");
        run_op(2'b01, 16'h0005, 16'h0003, 1'b0, "sub_pos");
        run_op(2'b01, 16'h0003, 16'h0005, 1'b1, "sub_neg");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_sum", sum0, 16'hFFFE);
            chk("hold_done", done0, 1'b0);
        end

        clr("clr1");
        mode = 2'b10; a = 16'h1000; b = 16'h0; cin = 1'b0; start = 1'b1;
        for (int k = 0; k < 3; k++) push(2'b10, 16'h1000, 16'h0, 1'b0);
        @(posedge clk); #1;
        ndone = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (done0) begin
                chk("b2b_done_at", k, 4 * (ndone + 1));
                ndone++;
            end
            if (k == 8) start = 1'b0;
        end
        chk("b2b_count", ndone, 3);
        chk("b2b_acc", acc0, 16'h3000);

        clr("clr2");
        run_op(2'b10, 16'h0500, 16'h0, 1'b0, "ld500");
        mode = 2'b10; a = 16'h0010; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0; start = 1'b1; mode = 2'b00;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy", {busy1, busy0}, 2'b00);
        chk("abort_acc", {acc1, acc0}, 32'h0);
        chk("abort_done", {done1, done0}, 2'b00);
        rst_n = 1'b1; start = 1'b0;
        accm0 = 16'h0; accm1 = 16'h0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("abort_quiet", {done0, busy0}, 2'b00);
        end

        run_op(2'b10, 16'h0010, 16'h0, 1'b1, "acc_cin");
        run_op(2'b10, 16'hFFFF, 16'h0, 1'b0, "acc_sat");
        for (int k = 0; k < 6; k++) begin
            run_op(2'($urandom_range(0, 2)), 16'($urandom), 16'($urandom),
                   1'($urandom), "rand");
        end

        repeat (2) @(negedge clk);
        chk("sb_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/chunked_adder_accum.md
CHUNKED_ADDER_ACCUM -- requirements
Module: chunked_adder_accum

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits (>=4).
REQ-002 SHALL have parameter CHUNK, default 4, bits added per clock; WIDTH % CHUNK == 0; NCH = WIDTH/CHUNK.
REQ-003 SHALL have parameter SAT, default 0; 0 = wrapping result, 1 = unsigned saturating result.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port start  input  1  operation request, sampled every edge.
REQ-007 SHALL have port mode  input  2  00 A+B+cin, 01 A-B, 10 ACC+A+cin, 11 clear ACC.
REQ-008 SHALL have ports a, b  input  WIDTH each  operands.
REQ-009 SHALL have port cin  input  1  carry-in for modes 00/10.
REQ-010 SHALL have port busy  output  1  high while an operation is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse when results update.
REQ-012 SHALL have port sum  output  WIDTH  registered result.
REQ-013 SHALL have ports cout, ovf  output  1 each  raw carry-out; signed two's-complement overflow.
REQ-014 SHALL have port acc  output  WIDTH  accumulator register.

Function
REQ-015 SHALL implement FSM states IDLE and RUN, plus a chunk counter 0..NCH-1.
REQ-016 In IDLE with start=1 and mode!=11, the block SHALL latch operands, mode and carry-in, clear the counter, and enter RUN. busy=1 from that edge onward.
REQ-017 Operand latching: mode 00 uses (a,b,cin); mode 01 uses (a,~b,1) and ignores cin; mode 10 uses (acc,a,cin).
REQ-018 In RUN, each edge SHALL add chunk i (bits i*CHUNK+CHUNK-1 : i*CHUNK), LSB chunk first, using the carry registered from chunk i-1. Chunk 0 SHALL use the latched carry-in.
REQ-019 At the edge that processes chunk NCH-1, the block SHALL:
  - update sum, cout and ovf;
  - set done=1 and busy=0;
  - return to IDLE.
  Latency from the start-sampling edge to done SHALL be exactly NCH cycles.
REQ-020 cout SHALL be the carry out of the MSB. For mode 01, cout=1 means no borrow.
REQ-021 ovf SHALL be 1 when both effective operand MSBs are equal and the unsaturated result MSB differs from them.
REQ-022 With SAT=1, sum SHALL be all-ones on cout=1 in modes 00/10, and zero on cout=0 in mode 01. cout and ovf SHALL still report raw values.
REQ-023 acc SHALL load the final sum only on completion of mode 10; modes 00/01 SHALL leave acc unchanged.
REQ-024 Mode 11 with start=1 in IDLE SHALL, at that edge:
  - clear acc and sum;
  - clear cout and ovf;
  - pulse done;
  - keep busy=0 and remain in IDLE.
REQ-025 start SHALL be ignored while in RUN; no request is queued.
REQ-026 start in the same cycle as done SHALL be accepted, giving back-to-back operations every NCH cycles.
REQ-027 sum, cout, ovf and acc SHALL hold their values between done pulses. done SHALL be low in every other cycle.
REQ-028 Changes on a/b/cin/mode during RUN SHALL NOT affect the in-flight result.

Reset
REQ-029 When rst_n=0 at an edge, the block SHALL:
  - enter IDLE;
  - set busy=0, done=0, sum=0, cout=0, ovf=0, acc=0;
  - clear the counter and internal carry.
REQ-030 Reset asserted mid-RUN SHALL abort the operation with no done pulse and no acc update. Reset SHALL take priority over start.

Verification (WIDTH=16, CHUNK=4, NCH=4)
REQ-031 Basic add, SAT=0:
  - Stimulus: start, mode=00, a=0x00FF, b=0x0001, cin=0.
  - Response: done exactly 4 cycles later; sum=0x0100, cout=0, ovf=0; busy high for the 4 cycles.
REQ-032 Carry and overflow:
  - Stimulus: mode=00, a=0xFFFF, b=0x0001, cin=1.
  - Response with SAT=0: sum=0x0001, cout=1, ovf=0.
  - Stimulus: mode=00, a=0x7FFF, b=0x0001, cin=0.
  - Response with SAT=0: sum=0x8000, ovf=1, cout=0.
  - Response with SAT=1, first case: sum=0xFFFF.
REQ-033 Subtract:
  - Stimulus: mode=01, a=0x0003, b=0x0005, cin=1.
  - Response with SAT=0: sum=0xFFFE, cout=0.
  - Response with SAT=1: sum=0x0000.
REQ-034 Accumulate:
  - Stimulus: mode=11, then three back-to-back mode=10 with a=0x1000, start held high through each done.
  - Response: done pulses 4 cycles apart; acc=0x1000, 0x2000, 0x3000.
  - Response: start pulses during RUN produce no extra done.
REQ-035 Reset mid-op:
  - Stimulus: mode=10, a=0x0010, with acc=0x0500 beforehand; rst_n=0 two cycles after start.
  - Response: next cycle busy=0 and acc=0.
  - Response: no done pulse for the aborted operation.
